// File: rtl/rx_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_parser_if
// Description : Bundle of the receive byte stream, the header/payload FIFO
//               write ports and the statistics counters of rx_frame_parser.
//               master = the parser side, slave = the surrounding logic.
// Revision    : 1.0  initial release
// ============================================================================
interface rx_frame_parser_if #(
    parameter int CNT_W = 16
);
    // receive byte stream
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_eof;
    logic             rx_err;
    // header FIFO write side
    logic [114:0]     h_din;
    logic             h_wren;
    logic             h_afull;
    // payload FIFO write side
    logic [7:0]       b_din;
    logic             b_del;
    logic             b_wren;
    logic             b_afull;
    // statistics
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] bad_cnt;

    modport master (
        input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, h_afull, b_afull,
        output h_din, h_wren, b_din, b_del, b_wren, frame_cnt, drop_cnt, bad_cnt
    );

    modport slave (
        output rx_data, rx_valid, rx_sof, rx_eof, rx_err, h_afull, b_afull,
        input  h_din, h_wren, b_din, b_del, b_wren, frame_cnt, drop_cnt, bad_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_parser
// Description : Per-port ingress parser. Splits a received byte stream into
//               one 115-bit header FIFO entry per frame
//               {VALID, PORT, DST, SRC, TYPE} and a 9-bit payload FIFO stream
//               terminated by a delimiter entry. Frames are dropped whole when
//               the header FIFO is almost full at start of frame.
// Revision    : 1.0  initial release
// ============================================================================
module rx_frame_parser #(
    parameter logic [1:0] PORT_ID     = 2'd0,
    parameter int         MAX_PAYLOAD = 1500,
    parameter int         CNT_W       = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    rx_frame_parser_if.master   pif
);

    localparam int                PC_W       = $clog2(MAX_PAYLOAD + 1);
    localparam logic [PC_W-1:0]   C_MAX_PAY  = PC_W'(MAX_PAYLOAD);
    localparam logic [3:0]        C_LAST_HDR = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BODY  = 3'd2,
        S_CLOSE = 3'd3,
        S_DROP  = 3'd4
    } state_t;

    state_t             state_q,    state_d;
    logic [111:0]       hdr_q,      hdr_d;       // {DST, SRC, TYPE}
    logic [3:0]         hcnt_q,     hcnt_d;      // header bytes received
    logic [PC_W-1:0]    pcnt_q,     pcnt_d;      // payload bytes received (saturates at max)
    logic               bad_q,      bad_d;       // sticky error/overflow/oversize
    logic               pend_q,     pend_d;      // close write still owed in CLOSE

    logic [114:0]       h_din_q,    h_din_d;
    logic               h_wren_q,   h_wren_d;
    logic [7:0]         b_din_q,    b_din_d;
    logic               b_del_q,    b_del_d;
    logic               b_wren_q,   b_wren_d;

    logic [CNT_W-1:0]   frame_q,    frame_d;
    logic [CNT_W-1:0]   drop_q,     drop_d;
    logic [CNT_W-1:0]   badc_q,     badc_d;

    logic               close_now;   // issue delimiter + header at this edge
    logic               close_ok;    // FRAME_VALID of the header being issued
    logic               drop_now;    // a dropped frame finishes at this edge

    logic               w_sof;
    logic               w_eof;

    assign w_sof = pif.rx_valid & pif.rx_sof;
    assign w_eof = pif.rx_valid & pif.rx_eof;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // State register, frame context, FIFO write registers and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hdr_q    <= '0;
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            bad_q    <= 1'b0;
            pend_q   <= 1'b0;
            h_din_q  <= '0;
            h_wren_q <= 1'b0;
            b_din_q  <= '0;
            b_del_q  <= 1'b0;
            b_wren_q <= 1'b0;
            frame_q  <= '0;
            drop_q   <= '0;
            badc_q   <= '0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            hcnt_q   <= hcnt_d;
            pcnt_q   <= pcnt_d;
            bad_q    <= bad_d;
            pend_q   <= pend_d;
            h_din_q  <= h_din_d;
            h_wren_q <= h_wren_d;
            b_din_q  <= b_din_d;
            b_del_q  <= b_del_d;
            b_wren_q <= b_wren_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            badc_q   <= badc_d;
        end
    end

    // Next-state, header capture, payload forwarding and frame close decisions
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        bad_d     = bad_q;
        pend_d    = pend_q;
        h_din_d   = h_din_q;
        h_wren_d  = 1'b0;
        b_din_d   = b_din_q;
        b_del_d   = b_del_q;
        b_wren_d  = 1'b0;
        frame_d   = frame_q;
        drop_d    = drop_q;
        badc_d    = badc_q;
        close_now = 1'b0;
        close_ok  = 1'b0;
        drop_now  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_sof) begin
                    if (pif.h_afull) begin
                        // No guaranteed header slot: the whole frame is dropped
                        if (w_eof) drop_now = 1'b1;
                        else       state_d  = S_DROP;
                    end else begin
                        hdr_d  = {pif.rx_data, 104'd0};
                        hcnt_d = 4'd1;
                        pcnt_d = '0;
                        bad_d  = pif.rx_err;
                        pend_d = 1'b0;
                        if (w_eof) begin
                            // single-byte runt closes immediately
                            close_now = 1'b1;
                            close_ok  = 1'b0;
                            state_d   = S_CLOSE;
                        end else begin
                            state_d   = S_HDR;
                        end
                    end
                end
            end

            S_HDR, S_BODY: begin
                if (w_sof) begin
                    // Missing eof: current frame closes invalid, new one is dropped.
                    // Nothing else is being written at this edge, so close now.
                    close_now = 1'b1;
                    close_ok  = 1'b0;
                    pend_d    = 1'b0;
                    if (w_eof) begin
                        drop_now = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_DROP;
                    end
                end else if (pif.rx_valid) begin
                    bad_d = bad_q | pif.rx_err;
                    if (state_q == S_HDR) begin
                        // Positional store so missing runt bytes stay zero
                        for (int i = 0; i < 14; i++) begin
                            if (hcnt_q == 4'(i)) hdr_d[111-8*i -: 8] = pif.rx_data;
                        end
                        hcnt_d = hcnt_q + 4'd1;
                        if (w_eof) begin
                            // Header path has no payload write in flight: close now
                            close_now = 1'b1;
                            close_ok  = ~(bad_q | pif.rx_err) & (hcnt_q == C_LAST_HDR);
                            pend_d    = 1'b0;
                            state_d   = S_CLOSE;
                        end else if (hcnt_q == C_LAST_HDR) begin
                            state_d   = S_BODY;
                        end
                    end else begin
                        if (!pif.b_afull && (pcnt_q < C_MAX_PAY)) begin
                            b_wren_d = 1'b1;
                            b_del_d  = 1'b0;
                            b_din_d  = pif.rx_data;
                        end else begin
                            bad_d    = 1'b1;
                        end
                        if (pcnt_q < C_MAX_PAY) pcnt_d = pcnt_q + 1'b1;
                        if (w_eof) begin
                            // The eof byte occupies this edge; the close follows in CLOSE
                            pend_d  = 1'b1;
                            state_d = S_CLOSE;
                        end
                    end
                end
            end

            S_CLOSE: begin
                if (pend_q) begin
                    close_now = 1'b1;
                    close_ok  = ~bad_q;
                end
                pend_d = 1'b0;
                if (w_sof) begin
                    // No idle gap after eof: the new frame cannot be parsed
                    if (w_eof) begin
                        drop_now = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_DROP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_DROP: begin
                if (w_eof) begin
                    drop_now = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (close_now) begin
            b_wren_d = 1'b1;
            b_del_d  = 1'b1;
            b_din_d  = 8'h00;
            h_wren_d = 1'b1;
            h_din_d  = {close_ok, PORT_ID, hdr_d};
            frame_d  = sat_inc(frame_q);
            if (!close_ok) badc_d = sat_inc(badc_q);
        end
        if (drop_now) begin
            drop_d = sat_inc(drop_q);
        end
    end

    assign pif.h_din     = h_din_q;
    assign pif.h_wren    = h_wren_q;
    assign pif.b_din     = b_din_q;
    assign pif.b_del     = b_del_q;
    assign pif.b_wren    = b_wren_q;
    assign pif.frame_cnt = frame_q;
    assign pif.drop_cnt  = drop_q;
    assign pif.bad_cnt   = badc_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_parser
// Description : Directed self-checking bench for rx_frame_parser.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_frame_parser;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;

    rx_frame_parser_if #(.CNT_W(CNT_W)) bus ();

    rx_frame_parser #(
        .PORT_ID     (2'd2),
        .MAX_PAYLOAD (1500),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Write monitor, sampled on the falling edge away from output updates
    int           pay_wr;
    int           del_wr;
    int           hdr_wr;
    int           pair_err;
    int           pay_sum;
    logic [114:0] last_hdr;

    initial begin
        pay_wr = 0; del_wr = 0; hdr_wr = 0; pair_err = 0; pay_sum = 0;
        last_hdr = '0;
    end

    always @(negedge clk) begin
        if (bus.b_wren && !bus.b_del) begin
            pay_wr  = pay_wr + 1;
            pay_sum = pay_sum + int'(bus.b_din);
        end
        if (bus.b_wren && bus.b_del) del_wr = del_wr + 1;
        if (bus.h_wren) begin
            hdr_wr   = hdr_wr + 1;
            last_hdr = bus.h_din;
        end
        if (bus.h_wren !== (bus.b_wren & bus.b_del)) pair_err = pair_err + 1;
    end

    localparam logic [111:0] C_HDR = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800};

    function automatic logic [7:0] pay_byte(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    function automatic int pay_sum_of(input int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) s = s + int'(pay_byte(k));
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors = vectors + 1;
        assert (got === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends nbytes of a frame; returns 1 time unit after the last byte's edge
    task automatic send_frame(input int nbytes, input int err_at, input bit eof_en,
                              input int bafull_at);
        logic [111:0] hv;
        hv = C_HDR;
        for (int i = 0; i < nbytes; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = (i < 14) ? hv[111-8*i -: 8] : pay_byte(i - 14);
            bus.rx_sof   = (i == 0);
            bus.rx_eof   = eof_en && (i == nbytes - 1);
            bus.rx_err   = (i == err_at);
            if (bafull_at >= 0 && i >= bafull_at) bus.b_afull = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b0;
        bus.rx_eof   = 1'b0;
        bus.rx_err   = 1'b0;
        bus.b_afull  = 1'b0;
    endtask

    int p0, d0, h0, s0;

    task automatic snap();
        p0 = pay_wr; d0 = del_wr; h0 = hdr_wr; s0 = pay_sum;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_sof = 1'b0;
        bus.rx_eof = 1'b0; bus.rx_err = 1'b0;
        bus.h_afull = 1'b0; bus.b_afull = 1'b0;
        idle(3);

        // Reset state
        chk("rst_h_wren", 128'(bus.h_wren), 128'd0);
        chk("rst_b_wren", 128'(bus.b_wren), 128'd0);
        chk("rst_h_din",  128'(bus.h_din),  128'd0);
        chk("rst_frame",  128'(bus.frame_cnt), 128'd0);
        rst_n = 1'b1;
        idle(2);

        // 64-byte good frame, with eof latency checks
        snap();
        send_frame(64, -1, 1'b1, -1);
        chk("f1_eof_pay_wr",  128'({bus.b_wren, bus.b_del, bus.h_wren}), 128'(3'b100));
        chk("f1_eof_pay_din", 128'(bus.b_din), 128'(pay_byte(49)));
        idle(1);
        chk("f1_close", 128'({bus.b_wren, bus.b_del, bus.h_wren}), 128'(3'b111));
        idle(3);
        chk("f1_pay_wr",  128'(pay_wr - p0), 128'd50);
        chk("f1_pay_sum", 128'(pay_sum - s0), 128'(pay_sum_of(50)));
        chk("f1_del",     128'(del_wr - d0), 128'd1);
        chk("f1_hdr",     128'(last_hdr), 128'({1'b1, 2'd2, C_HDR}));
        chk("f1_frame",   128'(bus.frame_cnt), 128'd1);
        chk("f1_bad",     128'(bus.bad_cnt), 128'd0);

        // Same frame with rx_err on byte 20
        snap();
        send_frame(64, 20, 1'b1, -1);
        idle(4);
        chk("f2_pay_wr", 128'(pay_wr - p0), 128'd50);
        chk("f2_hdr",    128'(last_hdr), 128'({1'b0, 2'd2, C_HDR}));
        chk("f2_bad",    128'(bus.bad_cnt), 128'd1);
        chk("f2_frame",  128'(bus.frame_cnt), 128'd2);

        // 10-byte runt: close visible right after the eof edge
        snap();
        send_frame(10, -1, 1'b1, -1);
        chk("f3_close", 128'({bus.b_wren, bus.b_del, bus.h_wren}), 128'(3'b111));
        idle(3);
        chk("f3_pay_wr", 128'(pay_wr - p0), 128'd0);
        chk("f3_hdr", 128'(last_hdr),
            128'({1'b0, 2'd2, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0000, 16'h0000}));
        chk("f3_bad", 128'(bus.bad_cnt), 128'd2);

        // Header FIFO almost full at sof: frame dropped whole
        snap();
        bus.h_afull = 1'b1;
        send_frame(64, -1, 1'b1, -1);
        bus.h_afull = 1'b0;
        idle(3);
        chk("f4_writes", 128'((pay_wr - p0) + (del_wr - d0) + (hdr_wr - h0)), 128'd0);
        chk("f4_drop",   128'(bus.drop_cnt), 128'd1);
        chk("f4_frame",  128'(bus.frame_cnt), 128'd3);

        // Next frame parses normally
        snap();
        send_frame(64, -1, 1'b1, -1);
        idle(4);
        chk("f5_pay_wr", 128'(pay_wr - p0), 128'd50);
        chk("f5_hdr",    128'(last_hdr), 128'({1'b1, 2'd2, C_HDR}));
        chk("f5_frame",  128'(bus.frame_cnt), 128'd4);

        // Payload FIFO almost full from payload byte 10
        snap();
        send_frame(64, -1, 1'b1, 24);
        idle(4);
        chk("f6_pay_wr",  128'(pay_wr - p0), 128'd10);
        chk("f6_pay_sum", 128'(pay_sum - s0), 128'(pay_sum_of(10)));
        chk("f6_del",     128'(del_wr - d0), 128'd1);
        chk("f6_valid",   128'(last_hdr[114]), 128'd0);
        chk("f6_bad",     128'(bus.bad_cnt), 128'd3);

        // Oversize: 1600-byte payload, only 1500 forwarded
        snap();
        send_frame(14 + 1600, -1, 1'b1, -1);
        idle(4);
        chk("f7_pay_wr", 128'(pay_wr - p0), 128'd1500);
        chk("f7_valid",  128'(last_hdr[114]), 128'd0);
        chk("f7_frame",  128'(bus.frame_cnt), 128'd6);
        chk("f7_bad",    128'(bus.bad_cnt), 128'd4);

        // Frame A without eof, frame B starts at A's byte 30
        snap();
        send_frame(30, -1, 1'b0, -1);
        send_frame(64, -1, 1'b1, -1);
        idle(4);
        chk("f8_pay_wr", 128'(pay_wr - p0), 128'd16);
        chk("f8_hdr_wr", 128'(hdr_wr - h0), 128'd1);
        chk("f8_hdr",    128'(last_hdr), 128'({1'b0, 2'd2, C_HDR}));
        chk("f8_drop",   128'(bus.drop_cnt), 128'd2);
        chk("f8_frame",  128'(bus.frame_cnt), 128'd7);
        chk("f8_pair",   128'(pair_err), 128'd0);

        // Reset in the middle of a payload
        send_frame(30, -1, 1'b0, -1);
        rst_n = 1'b0;
        idle(2);
        chk("rst2_out",   128'({bus.h_wren, bus.b_wren, bus.b_del, bus.b_din}), 128'd0);
        chk("rst2_cnts",  128'({bus.frame_cnt, bus.drop_cnt, bus.bad_cnt}), 128'd0);
        rst_n = 1'b1;
        idle(1);
        snap();
        send_frame(64, -1, 1'b1, -1);
        idle(4);
        chk("rst2_next_pay", 128'(pay_wr - p0), 128'd50);
        chk("rst2_next_hdr", 128'(last_hdr), 128'({1'b1, 2'd2, C_HDR}));
        chk("rst2_frame",    128'(bus.frame_cnt), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
